// File: rtl/id_stage_decoder_pkg.sv
// Shared encodings for the ID/EX and EX stages: opcodes, ALU control codes,
// instruction field positions and the decoded control bundle.
package id_stage_decoder_pkg;

  localparam int XLEN    = 16;
  localparam int REG_AW  = 4;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_SLT  = 4'h4,
    OP_ADDI = 4'h5,
    OP_LW   = 4'h6,
    OP_SW   = 4'h7,
    OP_NOP  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_ctl_e;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
  } ctrl_t;

  function automatic logic [XLEN-1:0] sign_extend_imm(input logic [IMM_MSB-IMM_LSB:0] imm);
    return {{(XLEN-(IMM_MSB-IMM_LSB+1)){imm[IMM_MSB-IMM_LSB]}}, imm};
  endfunction

endpackage

// File: rtl/id_stage_decoder_reg_file.sv
// Two-read, one-write register file with write-back bypass; register 0 is hardwired to zero.
module id_stage_decoder_reg_file
  import id_stage_decoder_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0) && (int'(waddr_i) < REG_COUNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A read of the register being written this cycle sees the incoming value.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != '0 && int'(raddr1_i) < REG_COUNT) begin
      rdata1_o = (wr_en && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
    end
    if (raddr2_i != '0 && int'(raddr2_i) < REG_COUNT) begin
      rdata2_o = (wr_en && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/id_stage_decoder.sv
// Instruction decode stage: IF/ID register, field decode, control generation,
// load-use hazard detection and register-file read.
module id_stage_decoder
  import id_stage_decoder_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   instr_in,
  input  logic              instr_valid_in,
  input  logic              flush_in,
  input  logic              wb_reg_write_in,
  input  logic [REG_AW-1:0] wb_rd_in,
  input  logic [XLEN-1:0]   wb_data_in,
  input  logic              ex_mem_read_in,
  input  logic [REG_AW-1:0] ex_rd_in,
  output logic [XLEN-1:0]   reg_data1_out,
  output logic [XLEN-1:0]   reg_data2_out,
  output logic [XLEN-1:0]   sign_ext_out,
  output logic [REG_AW-1:0] rs_out,
  output logic [REG_AW-1:0] rt_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [2:0]        alu_control_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              mem_to_reg_out,
  output logic              alu_src_out,
  output logic              stall_out,
  output logic              illegal_out,
  output logic [15:0]       stall_count_out
);

  logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              illegal_q, illegal_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rs_f, rt_f, rd_f, dest;
  ctrl_t             ctrl, ctrl_gated;
  logic              is_rtype, is_sw, is_illegal, stall, bubble;

  assign opcode = ifid_instr_q[OPC_MSB:OPC_LSB];
  assign rs_f   = ifid_instr_q[RS_MSB:RS_LSB];
  assign rt_f   = ifid_instr_q[RT_MSB:RT_LSB];
  assign rd_f   = ifid_instr_q[RD_MSB:RD_LSB];

  always_comb begin
    ctrl       = '0;
    dest       = rd_f;
    is_rtype   = 1'b0;
    is_sw      = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        ctrl.alu_control = opcode[2:0];
        ctrl.reg_write   = 1'b1;
        is_rtype         = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.alu_src     = 1'b1;
        ctrl.reg_write   = 1'b1;
        dest             = rt_f;
      end
      OP_LW: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.alu_src     = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.reg_write   = 1'b1;
        dest             = rt_f;
      end
      OP_SW: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.alu_src     = 1'b1;
        ctrl.mem_write   = 1'b1;
        is_sw            = 1'b1;
      end
      OP_NOP: ;
      default: is_illegal = 1'b1;
    endcase
  end

  // rt is only a true source operand for R-type and SW, so only those can stall on it.
  assign stall = ifid_valid_q && ex_mem_read_in && (ex_rd_in != '0) &&
                 ((ex_rd_in == rs_f) || ((ex_rd_in == rt_f) && (is_rtype || is_sw)));

  assign bubble     = !ifid_valid_q || stall;
  assign ctrl_gated = bubble ? '0 : ctrl;

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (flush_in) begin
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_instr_d = instr_in;
      ifid_valid_d = instr_valid_in;
    end
    illegal_d   = illegal_q | (ifid_valid_q & is_illegal);
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      illegal_q    <= illegal_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  id_stage_decoder_reg_file #(
    .REG_COUNT (REG_COUNT)
  ) u_reg_file (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .raddr1_i (rs_f),
    .raddr2_i (rt_f),
    .we_i     (wb_reg_write_in),
    .waddr_i  (wb_rd_in),
    .wdata_i  (wb_data_in),
    .rdata1_o (reg_data1_out),
    .rdata2_o (reg_data2_out)
  );

  assign sign_ext_out    = sign_extend_imm(ifid_instr_q[IMM_MSB:IMM_LSB]);
  assign rs_out          = rs_f;
  assign rt_out          = rt_f;
  assign rd_out          = ctrl_gated.reg_write ? dest : '0;
  assign alu_control_out = ctrl_gated.alu_control;
  assign reg_write_out   = ctrl_gated.reg_write;
  assign mem_read_out    = ctrl_gated.mem_read;
  assign mem_write_out   = ctrl_gated.mem_write;
  assign mem_to_reg_out  = ctrl_gated.mem_to_reg;
  assign alu_src_out     = ctrl_gated.alu_src;
  assign stall_out       = stall;
  assign illegal_out     = illegal_q;
  assign stall_count_out = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_decoder.sv
// Scoreboard bench for id_stage_decoder: each driven instruction queues the
// outputs expected one cycle later, which are popped and compared then.
module tb_id_stage_decoder;

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] se;
    logic [3:0]  rd;
    logic [2:0]  alu;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        as;
    logic        st;
    logic        il;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] instr_in;
  logic        instr_valid_in;
  logic        flush_in;
  logic        wb_reg_write_in;
  logic [3:0]  wb_rd_in;
  logic [15:0] wb_data_in;
  logic        ex_mem_read_in;
  logic [3:0]  ex_rd_in;
  logic [15:0] reg_data1_out, reg_data2_out, sign_ext_out;
  logic [3:0]  rs_out, rt_out, rd_out;
  logic [2:0]  alu_control_out;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, alu_src_out;
  logic        stall_out, illegal_out;
  logic [15:0] stall_count_out;

  int    compared   = 0;
  int    mismatched = 0;
  exp_t  sbQ[$];
  string tagQ[$];

  id_stage_decoder #(.REG_COUNT(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .instr_in        (instr_in),
    .instr_valid_in  (instr_valid_in),
    .flush_in        (flush_in),
    .wb_reg_write_in (wb_reg_write_in),
    .wb_rd_in        (wb_rd_in),
    .wb_data_in      (wb_data_in),
    .ex_mem_read_in  (ex_mem_read_in),
    .ex_rd_in        (ex_rd_in),
    .reg_data1_out   (reg_data1_out),
    .reg_data2_out   (reg_data2_out),
    .sign_ext_out    (sign_ext_out),
    .rs_out          (rs_out),
    .rt_out          (rt_out),
    .rd_out          (rd_out),
    .alu_control_out (alu_control_out),
    .reg_write_out   (reg_write_out),
    .mem_read_out    (mem_read_out),
    .mem_write_out   (mem_write_out),
    .mem_to_reg_out  (mem_to_reg_out),
    .alu_src_out     (alu_src_out),
    .stall_out       (stall_out),
    .illegal_out     (illegal_out),
    .stall_count_out (stall_count_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] se,
                                 input logic [3:0] rd, input logic [2:0] alu, input logic rw,
                                 input logic mr, input logic mw, input logic m2r, input logic as,
                                 input logic st, input logic il, input logic [15:0] cnt);
    exp_t e;
    e = '{d1: d1, d2: d2, se: se, rd: rd, alu: alu, rw: rw, mr: mr, mw: mw,
          m2r: m2r, as: as, st: st, il: il, cnt: cnt};
    return e;
  endfunction

  task automatic compareAll(input string tag, input exp_t e);
    checkOutput({tag, ".data1"},  reg_data1_out,           e.d1);
    checkOutput({tag, ".data2"},  reg_data2_out,           e.d2);
    checkOutput({tag, ".sext"},   sign_ext_out,            e.se);
    checkOutput({tag, ".rd"},     {12'd0, rd_out},          {12'd0, e.rd});
    checkOutput({tag, ".alu"},    {13'd0, alu_control_out}, {13'd0, e.alu});
    checkOutput({tag, ".regwr"},  {15'd0, reg_write_out},   {15'd0, e.rw});
    checkOutput({tag, ".memrd"},  {15'd0, mem_read_out},    {15'd0, e.mr});
    checkOutput({tag, ".memwr"},  {15'd0, mem_write_out},   {15'd0, e.mw});
    checkOutput({tag, ".m2r"},    {15'd0, mem_to_reg_out},  {15'd0, e.m2r});
    checkOutput({tag, ".alusrc"}, {15'd0, alu_src_out},     {15'd0, e.as});
    checkOutput({tag, ".stall"},  {15'd0, stall_out},       {15'd0, e.st});
    checkOutput({tag, ".illegal"},{15'd0, illegal_out},     {15'd0, e.il});
    checkOutput({tag, ".stcnt"},  stall_count_out,          e.cnt);
  endtask

  // One cycle: drive inputs at the falling edge, compare last cycle's expectation, queue the next.
  task automatic applyStimulus(input logic [15:0] instr, input logic valid, input logic flush,
                               input logic wbWe, input logic [3:0] wbRd, input logic [15:0] wbData,
                               input logic exMr, input logic [3:0] exRd,
                               input bit doPush, input string tag, input exp_t e);
    @(negedge clk);
    instr_in        = instr;
    instr_valid_in  = valid;
    flush_in        = flush;
    wb_reg_write_in = wbWe;
    wb_rd_in        = wbRd;
    wb_data_in      = wbData;
    ex_mem_read_in  = exMr;
    ex_rd_in        = exRd;
    #1;
    if (sbQ.size() > 0) begin
      compareAll(tagQ.pop_front(), sbQ.pop_front());
    end
    if (doPush) begin
      sbQ.push_back(e);
      tagQ.push_back(tag);
    end
  endtask

  initial begin
    exp_t z;
    z = '0;
    reset_n         = 1'b0;
    instr_in        = '0;
    instr_valid_in  = 1'b0;
    flush_in        = 1'b0;
    wb_reg_write_in = 1'b0;
    wb_rd_in        = '0;
    wb_data_in      = '0;
    ex_mem_read_in  = 1'b0;
    ex_rd_in        = '0;

    #3;
    compareAll("reset", z);
    @(negedge clk);
    reset_n = 1'b1;

    //            instr    v  fl wbWe wbRd  wbData    exMr exRd
    applyStimulus(16'h0335, 1, 0, 1, 4'd3, 16'h1234, 0, 4'd0, 1, "add_r5_r3_r3",
                  mkExp(16'h1234, 16'h1234, 16'h0005, 4'd5, 3'b000, 1, 0, 0, 0, 0, 0, 0, 16'd0));
    applyStimulus(16'h512C, 1, 0, 0, 4'd0, 16'h0000, 0, 4'd0, 1, "addi_r2_r1",
                  mkExp(16'h0000, 16'h0000, 16'hFFFC, 4'd2, 3'b000, 1, 0, 0, 0, 1, 0, 0, 16'd0));
    applyStimulus(16'h1416, 1, 0, 0, 4'd0, 16'h0000, 0, 4'd0, 1, "sub_loaduse_stall",
                  mkExp(16'h0000, 16'h0000, 16'h0006, 4'd0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 16'd0));
    applyStimulus(16'h3708, 1, 0, 0, 4'd0, 16'h0000, 1, 4'd4, 1, "sub_held_after_stall",
                  mkExp(16'h0000, 16'h0000, 16'h0006, 4'd6, 3'b001, 1, 0, 0, 0, 0, 0, 0, 16'd1));
    applyStimulus(16'h3708, 1, 0, 0, 4'd0, 16'h0000, 0, 4'd0, 1, "or_wb_bypass",
                  mkExp(16'hBEEF, 16'h0000, 16'hFFF8, 4'd8, 3'b011, 1, 0, 0, 0, 0, 0, 0, 16'd1));
    applyStimulus(16'h9000, 1, 0, 1, 4'd7, 16'hBEEF, 0, 4'd0, 1, "illegal_decode",
                  mkExp(16'h0000, 16'h0000, 16'h0000, 4'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 16'd1));
    applyStimulus(16'h7730, 1, 0, 0, 4'd0, 16'h0000, 0, 4'd0, 1, "sw_illegal_sticky",
                  mkExp(16'hBEEF, 16'h1234, 16'h0000, 4'd0, 3'b000, 0, 0, 1, 0, 1, 0, 1, 16'd1));
    applyStimulus(16'h6390, 1, 0, 0, 4'd0, 16'h0000, 0, 4'd0, 1, "lw_stall_rs",
                  mkExp(16'h1234, 16'h0000, 16'h0000, 4'd0, 3'b000, 0, 0, 0, 0, 0, 1, 1, 16'd1));
    applyStimulus(16'hF000, 1, 1, 0, 4'd0, 16'h0000, 1, 4'd3, 1, "flush_clears_valid",
                  mkExp(16'h1234, 16'h0000, 16'h0000, 4'd0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 16'd2));
    applyStimulus(16'h1416, 1, 0, 0, 4'd0, 16'h0000, 1, 4'd3, 1, "sub_stall_again",
                  mkExp(16'h0000, 16'h0000, 16'h0006, 4'd0, 3'b000, 0, 0, 0, 0, 0, 1, 1, 16'd2));
    applyStimulus(16'h0000, 0, 0, 0, 4'd0, 16'h0000, 1, 4'd4, 0, "", z);

    #2;
    reset_n = 1'b0;
    #1;
    compareAll("reset_mid_stall", z);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("sb_drained", 16'(sbQ.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_stage_decoder.md
ID_STAGE_DECODER -- requirements
Module: id_stage_decoder

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: instr_in  input  16  fetched instruction; instr_valid_in  input  1  instr_in meaningful this cycle.
REQ-004 SHALL have port: flush_in  input  1  discard IF/ID contents (branch redirect).
REQ-005 SHALL have ports: wb_reg_write_in  input  1; wb_rd_in  input  4; wb_data_in  input  16  (write-back port).
REQ-006 SHALL have ports: ex_mem_read_in  input  1; ex_rd_in  input  4  (EX-stage instruction's load flag and destination, for load-use detection).
REQ-007 SHALL have outputs: reg_data1_out, reg_data2_out, sign_ext_out  16 each; rs_out, rt_out, rd_out  4 each; alu_control_out  3; reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, alu_src_out  1 each (all drive the ID/EX register).
REQ-008 SHALL have outputs: stall_out  1  hold fetch; illegal_out  1  sticky illegal-opcode flag; stall_count_out  16  saturating stall counter.
REQ-009 SHALL use parameter: REG_COUNT, default 16, register-file depth.

Function
REQ-010 SHALL hold an internal IF/ID register (16-bit instruction plus valid bit) loaded from instr_in/instr_valid_in on each rising edge unless stall_out is high.
REQ-011 SHALL clear IF/ID valid on a rising edge when flush_in is high; flush_in takes priority over stall_out.
REQ-012 SHALL decode fields: opcode[15:12], rs[11:8], rt[7:4], rd[3:0]; imm[3:0] sign-extended to 16 bits on sign_ext_out.
REQ-013 SHALL decode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (R-type, alu_control = opcode[2:0], reg_write=1, rd_out=rd); 5 ADDI (alu_src=1, reg_write=1, rd_out=rt); 6 LW (alu_src, mem_read, mem_to_reg, reg_write, rd_out=rt); 7 SW (alu_src, mem_write, reg_write=0); F NOP.
REQ-014 SHALL use alu_control 000 for ADDI, LW, SW.
REQ-015 SHALL treat opcodes 8-E as NOP and set illegal_out on the following edge; illegal_out stays set until reset.
REQ-016 SHALL drive all control outputs to 0 (bubble) when IF/ID valid is 0, when decode is NOP/illegal, or when stall_out is high.
REQ-017 SHALL contain a REG_COUNT x 16 register file, written at rising edge when wb_reg_write_in=1 and wb_rd_in != 0; register 0 reads as 0 always.
REQ-018 SHALL bypass write-back: same-cycle read of the register being written returns wb_data_in (except register 0).
REQ-019 SHALL assert stall_out combinationally when IF/ID valid, ex_mem_read_in=1, ex_rd_in != 0, and ex_rd_in equals rs, or equals rt for R-type/SW.
REQ-020 SHALL increment stall_count_out on each edge with stall_out high, saturating at 0xFFFF.
REQ-021 SHALL have decode latency of one cycle: instruction accepted at edge N appears on outputs during cycle N+1.

Reset
REQ-022 SHALL, on reset_n low, immediately clear IF/ID valid and instruction, illegal_out, stall_count_out, and all register-file entries to 0.
REQ-023 SHALL, consequently, present all control outputs, data outputs, and stall_out at 0 during reset; reset mid-stall discards the held instruction.

Structure
REQ-024 SHALL take opcode encodings, ALU control codes, and field bit positions from a shared package used by the ID/EX and EX stages.
REQ-025 SHALL instantiate one sub-module, reg_file (2 read, 1 write, bypass); decoder, hazard, and IF/ID logic stay in the top module.

Verification
REQ-026 SHALL cover: WB write r3=0x1234 then ADD r5,r3,r3 -> reg_data1_out=reg_data2_out=0x1234, rd_out=5, alu_control_out=000, reg_write_out=1.
REQ-027 SHALL cover: ADDI r2,r1,imm=0xC -> sign_ext_out=0xFFFC, alu_src_out=1, rd_out=2.
REQ-028 SHALL cover: EX LW to r4 (ex_mem_read_in=1, ex_rd_in=4) with SUB r6,r4,r1 in ID -> stall_out=1, controls 0, IF/ID held, stall_count_out increments by 1.
REQ-029 SHALL cover: same-cycle WB to r7=0xBEEF while decoding OR r8,r7,r0 -> reg_data1_out=0xBEEF, reg_data2_out=0.
REQ-030 SHALL cover: opcode 0x9 -> all controls 0, illegal_out=1 next edge and held; flush_in with stall -> valid cleared, stall_out=0 next cycle.
REQ-031 SHALL cover: reset_n asserted mid-stall -> all outputs 0 immediately, stall_count_out=0.
